// File: rtl/conv2d_out_framer_if.sv
// Output stream bus of the conv2d output framer: pixel plus frame sideband,
// valid/ready handshake. The master drives data/valid/tags, the slave drives ready.
interface conv2d_out_framer_if #(
    parameter int PIXEL_BITS = 8
);
    logic [PIXEL_BITS-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/conv2d_out_framer.sv
// Output framer for a 3x3 convolution stage. Tracks the input raster position,
// keeps only the valid-window pixels (col>=2, row>=2), tags them with
// sof/eol/eof and buffers them in a first-word-fall-through FIFO that feeds a
// valid/ready stream. The input side cannot be stalled, so a kept pixel that
// finds the FIFO full is dropped and recorded in a sticky overflow flag.
module conv2d_out_framer #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int PIXEL_BITS = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    input  logic                  in_valid,
    conv2d_out_framer_if.master   m,
    output logic                  frame_done,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic [PIXEL_BITS-1:0] pixel;
    } entry_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    entry_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic            w_beat;
    logic [CW-1:0]   w_col;
    logic [RW-1:0]   w_row;
    logic            w_keep;
    logic            w_last;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_done;
    entry_t          w_head;
    entry_t          w_wr_entry;

    // Beat position, keep/tag decisions and FIFO handshake terms.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        w_beat     = in_valid && (frame_start || (r_state == RUN));
        // A frame_start beat is position (0,0) regardless of the old counters.
        w_col      = frame_start ? '0 : r_col;
        w_row      = frame_start ? '0 : r_row;
        w_keep     = w_beat && (w_col >= COL_FIRST) && (w_row >= ROW_FIRST);
        w_last     = w_beat && (w_col == COL_LAST) && (w_row == ROW_LAST);
        w_full     = (r_count == CNT_FULL);
        w_empty    = (r_count == '0);
        w_pop      = !w_empty && m.m_ready;
        // A full FIFO still takes the beat when the head leaves in the same cycle.
        w_push     = w_keep && (!w_full || w_pop);
        w_drop     = w_keep && !w_push;
        w_head     = r_mem[r_rd_ptr];
        w_wr_entry = '{sof:   (w_col == COL_FIRST) && (w_row == ROW_FIRST),
                       eol:   (w_col == COL_LAST),
                       eof:   (w_col == COL_LAST) && (w_row == ROW_LAST),
                       pixel: in_pixel};
        // Frame completes when its eof entry pops, or, if that entry was
        // dropped, once the FIFO has run dry.
        w_done     = (r_state == DRAIN) && ((w_pop && w_head.eof) || w_empty);
    end

    // Frame FSM and raster counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            if (frame_start) begin
                r_state <= RUN;
                r_col   <= '0;
                r_row   <= '0;
            end else if (w_done) begin
                r_state <= IDLE;
            end
            if (w_beat) begin
                if (w_last) begin
                    r_state <= DRAIN;
                    r_col   <= '0;
                    r_row   <= '0;
                end else if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; outputs are gated by occupancy instead.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Head of the FIFO drives the stream directly (fall-through), zeroed when empty.
    always_comb begin
        m.m_valid  = !w_empty;
        m.m_data   = w_empty ? '0 : w_head.pixel;
        m.m_sof    = !w_empty && w_head.sof;
        m.m_eol    = !w_empty && w_head.eol;
        m.m_eof    = !w_empty && w_head.eof;
        frame_done = w_done;
        overflow   = r_overflow;
    end

endmodule
